mips_lsu: RTL and testbench

- Load/store unit: the initiator for the word-only data memory (DM_ena/DM_R/DM_W port set).
- Accepts byte-addressed load/store requests from the CPU datapath.
- Sub-word stores (sb/sh) run as read-modify-write sequences over the word interface; sub-word loads are extracted with sign or zero extension.
- Sits between the EX stage and the data memory. Drives the memory's enable, read, write, address and write-data inputs, and samples its combinational read data.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_lane.sv | 38 +++
 rtl/mips_lsu.sv | 175 +++++++++++++++++
 tb/tb_mips_lsu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and request-decode helpers for the mips_lsu load/store unit.
// LSU_SUBWORD_EN selects whether the sub-word ops (lb/lbu/lh/lhu/sb/sh) are legal.
package lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4,
    SW  = 3'd5,
    SB  = 3'd6,
    SH  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_load(input logic [2:0] op);
    case (op)
      LW, LB, LBU, LH, LHU: is_load = 1'b1;
      default:              is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    case (op)
      LW, SW:  is_legal = 1'b1;
`ifdef LSU_SUBWORD_EN
      default: is_legal = 1'b1;
`else
      default: is_legal = 1'b0;
`endif
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] boff);
    case (op)
      LH, LHU, SH: is_misaligned = boff[0];
      LW, SW:      is_misaligned = (boff != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: little-endian sub-word extract with sign/zero extension
// for loads, and byte/halfword merge into a fetched word for stores.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  boff,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select, load extension and store merge.
  always_comb begin
    byte_s = word[{boff, 3'b000} +: 8];
    half_s = boff[1] ? word[31:16] : word[15:0];

    case (op)
      LB:      load_data = {{24{byte_s[7]}}, byte_s};
      LBU:     load_data = {24'd0, byte_s};
      LH:      load_data = {{16{half_s[15]}}, half_s};
      LHU:     load_data = {16'd0, half_s};
      default: load_data = word;
    endcase

    merge_data = word;
    case (op)
      SB:      merge_data[{boff, 3'b000} +: 8] = wdata[7:0];
      SH:      merge_data[{boff[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit driving a word-only data memory; sub-word stores run as
// read-modify-write. Optional sub-word support is enabled by LSU_SUBWORD_EN.
module mips_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        DM_ena,
  output logic        DM_R,
  output logic        DM_W,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  state_e      state_r, next_s;
  logic [2:0]  op_r;
  logic        oor_s, req_err_s, err_s;
  logic        busy_s, done_s, dm_ena_s, dm_r_s, dm_w_s;
  logic        busy_r, done_r, err_r, dm_ena_r, dm_r_r, dm_w_r;
  logic [31:0] rdata_r, mem_addr_r, mem_wdata_r;
  logic [31:0] load_s, merge_s;

  // Request check on the raw inputs; only consulted while IDLE.
  always_comb begin
    oor_s     = (|addr[31:IDX_W+2]) || ({1'b0, addr[IDX_W+1:2]} >= DEPTH_L);
    req_err_s = !is_legal(op) || is_misaligned(op, addr[1:0]) || oor_s;
  end

`ifdef LSU_SUBWORD_EN
  logic [1:0]  boff_r;
  logic [31:0] wdata_r;

  // Keep the request's lane offset and store data for the merge/extract.
  always_ff @(posedge clk) begin
    if (rst) begin
      boff_r  <= 2'b00;
      wdata_r <= 32'd0;
    end else if (state_r == IDLE && start) begin
      boff_r  <= addr[1:0];
      wdata_r <= wdata;
    end
  end

  lsu_lane u_lane (
    .op        (op_r),
    .boff      (boff_r),
    .word      (mem_rdata),
    .wdata     (wdata_r),
    .load_data (load_s),
    .merge_data(merge_s)
  );
`else
  assign load_s  = mem_rdata;
  assign merge_s = mem_rdata;
`endif

  // State register plus registered copies of every control output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      dm_ena_r <= 1'b0;
      dm_r_r   <= 1'b0;
      dm_w_r   <= 1'b0;
    end else begin
      state_r  <= next_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      err_r    <= err_s;
      dm_ena_r <= dm_ena_s;
      dm_r_r   <= dm_r_s;
      dm_w_r   <= dm_w_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (req_err_s) begin
            next_s = DONE;
            err_s  = 1'b1;
          end else if (op == SW) begin
            next_s = WRITE;
          end else begin
            next_s = READ;
          end
        end else begin
          next_s = IDLE;
        end
      end
      READ: begin
        if (is_load(op_r)) begin
          next_s = DONE;
        end else begin
          next_s = WRITE;
        end
      end
      WRITE:   next_s = DONE;
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register cleanly.
  always_comb begin
    busy_s   = (next_s != IDLE);
    done_s   = (next_s == DONE);
    dm_r_s   = (next_s == READ);
    dm_w_s   = (next_s == WRITE);
    dm_ena_s = dm_r_s || dm_w_s;
  end

  // Datapath: latch the request, capture read data, build the write word.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r        <= LW;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      rdata_r     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !req_err_s) begin
            op_r       <= op;
            mem_addr_r <= {2'b00, addr[31:2]};
            if (op == SW) begin
              mem_wdata_r <= wdata;
            end
          end
        end
        READ: begin
          if (is_load(op_r)) begin
            rdata_r <= load_s;
          end else begin
            mem_wdata_r <= merge_s;
          end
        end
        default: begin
          op_r <= op_r;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign DM_ena    = dm_ena_r;
  assign DM_R      = dm_r_r;
  assign DM_W      = dm_w_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: directed table from the test plan plus
// randomized requests checked against a byte-level reference model.
module tb_mips_lsu;
  import lsu_pkg::*;

`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, init;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        DM_ena, DM_R, DM_W;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] exp_rdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_lsu dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .DM_ena(DM_ena), .DM_R(DM_R), .DM_W(DM_W),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] pat(input int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // Data memory: combinational read, write on the edge closing a DM_W cycle.
  assign mem_rdata = (mem_addr < 32'd2048) ? mem[mem_addr[10:0]] : 32'd0;
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
    end else if (DM_ena && DM_W && mem_addr < 32'd2048) begin
      mem[mem_addr[10:0]] <= mem_wdata;
    end
  end

  // Reference model: byte-granular semantics, updates ref_mem and exp_rdata.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       output bit e, output int lat, output int nr, output int nw);
    int size, off, idx;
    bit ld, sgn;
    logic [31:0] mask, v;
    case (o)
      3'd0: begin size = 4; ld = 1; sgn = 0; end
      3'd1: begin size = 1; ld = 1; sgn = 1; end
      3'd2: begin size = 1; ld = 1; sgn = 0; end
      3'd3: begin size = 2; ld = 1; sgn = 1; end
      3'd4: begin size = 2; ld = 1; sgn = 0; end
      3'd5: begin size = 4; ld = 0; sgn = 0; end
      3'd6: begin size = 1; ld = 0; sgn = 0; end
      default: begin size = 2; ld = 0; sgn = 0; end
    endcase
    off  = int'(a[1:0]);
    mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
    e = ((off % size) != 0) || ((a >> 2) >= 32'd2048) || (!SUBWORD && size != 4);
    if (e) begin
      lat = 1; nr = 0; nw = 0;
    end else begin
      idx = int'(a >> 2);
      if (ld) begin
        v = (ref_mem[idx] >> (8 * off)) & mask;
        if (sgn && v[8 * size - 1]) v = v | ~mask;
        exp_rdata = v;
        lat = 2; nr = 1; nw = 0;
      end else begin
        ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        lat = (size == 4) ? 2 : 3;
        nr  = (size == 4) ? 0 : 1;
        nw  = 1;
      end
    end
  endtask

  // Issue one request and observe the bus until done (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e_o, output logic [31:0] rd_o,
                        output int nr, output int nw, output int nena, output int nbad,
                        output logic done_after);
    lat = 0; nr = 0; nw = 0; nena = 0; nbad = 0; e_o = 1'bx; rd_o = 32'hxxxxxxxx;
    @(negedge clk);
    start = 1'b1; op = o; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (DM_ena) nena++;
      if (DM_R) nr++;
      if (DM_W) nw++;
      if ((DM_R && DM_W) || ((DM_R || DM_W) && !DM_ena) ||
          (DM_ena && mem_addr !== {2'b00, a[31:2]})) nbad++;
      if (done) begin
        lat = c; e_o = err; rd_o = rdata;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b1; start = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);
    exp_rdata = 32'd0;
    repeat (2) @(negedge clk);
    init = 1'b0;
    checks++;
    if ({busy, done, err, DM_ena, DM_R, DM_W} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000", {busy, done, err, DM_ena, DM_R, DM_W});
    end
    checks++;
    if (rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h mem_addr=%h mem_wdata=%h exp 0", rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, wd;
    bit          e;
    int          lat, nr, nw;
    logic [31:0] rd, w4;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    bit me; int ml, mnr, mnw;
    int lat, nr, nw, nena, nbad;
    logic e_o, da;
    logic [31:0] rd_o;
`ifdef LSU_SUBWORD_EN
    tbl.push_back('{LB,  32'h11,   32'h0,        1'b0, 2, 1, 0, 32'hFFFFFFAA, 32'h8899AABB});
    tbl.push_back('{LBU, 32'h11,   32'h0,        1'b0, 2, 1, 0, 32'h000000AA, 32'h8899AABB});
    tbl.push_back('{LHU, 32'h12,   32'h0,        1'b0, 2, 1, 0, 32'h00008899, 32'h8899AABB});
    tbl.push_back('{LH,  32'h12,   32'h0,        1'b0, 2, 1, 0, 32'hFFFF8899, 32'h8899AABB});
    tbl.push_back('{SB,  32'h12,   32'h00000055, 1'b0, 3, 1, 1, 32'hFFFF8899, 32'h8855AABB});
    tbl.push_back('{LH,  32'h13,   32'h0,        1'b1, 1, 0, 0, 32'hFFFF8899, 32'h8855AABB});
    tbl.push_back('{LW,  32'h2002, 32'h0,        1'b1, 1, 0, 0, 32'hFFFF8899, 32'h8855AABB});
    tbl.push_back('{SW,  32'h10,   32'h12345678, 1'b0, 2, 0, 1, 32'hFFFF8899, 32'h12345678});
`else
    tbl.push_back('{LW,  32'h10,   32'h0,        1'b0, 2, 1, 0, 32'h8899AABB, 32'h8899AABB});
    tbl.push_back('{SB,  32'h10,   32'h00000055, 1'b1, 1, 0, 0, 32'h8899AABB, 32'h8899AABB});
    tbl.push_back('{LW,  32'h2002, 32'h0,        1'b1, 1, 0, 0, 32'h8899AABB, 32'h8899AABB});
    tbl.push_back('{LW,  32'h2000, 32'h0,        1'b1, 1, 0, 0, 32'h8899AABB, 32'h8899AABB});
    tbl.push_back('{SW,  32'h10,   32'h12345678, 1'b0, 2, 0, 1, 32'h8899AABB, 32'h12345678});
    tbl.push_back('{LW,  32'h10,   32'h0,        1'b0, 2, 1, 0, 32'h12345678, 32'h12345678});
`endif
    foreach (tbl[k]) begin
      model(tbl[k].o, tbl[k].a, tbl[k].wd, me, ml, mnr, mnw);
      run_op(tbl[k].o, tbl[k].a, tbl[k].wd, lat, e_o, rd_o, nr, nw, nena, nbad, da);
      checks++;
      if (lat !== tbl[k].lat || e_o !== tbl[k].e) begin
        errors++;
        $display("FAIL dir_lat_err #%0d got lat=%0d err=%b exp lat=%0d err=%b", k, lat, e_o, tbl[k].lat, tbl[k].e);
      end
      checks++;
      if (rd_o !== tbl[k].rd) begin
        errors++;
        $display("FAIL dir_rdata #%0d got %h exp %h", k, rd_o, tbl[k].rd);
      end
      checks++;
      if (nr !== tbl[k].nr || nw !== tbl[k].nw || nena !== tbl[k].nr + tbl[k].nw || nbad !== 0) begin
        errors++;
        $display("FAIL dir_bus #%0d got rd=%0d wr=%0d ena=%0d bad=%0d exp rd=%0d wr=%0d bad=0",
                 k, nr, nw, nena, nbad, tbl[k].nr, tbl[k].nw);
      end
      checks++;
      if (mem[4] !== tbl[k].w4 || da !== 1'b0) begin
        errors++;
        $display("FAIL dir_word4 #%0d got %h done_after=%b exp %h done_after=0", k, mem[4], da, tbl[k].w4);
      end
    end
  endtask

  task automatic test_random();
    bit me; int ml, mnr, mnw;
    int lat, nr, nw, nena, nbad, r;
    logic e_o, da;
    logic [31:0] rd_o, a, wd;
    logic [2:0] o;
    for (int k = 0; k < 150; k++) begin
      o  = 3'($urandom_range(0, 7));
      wd = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) a = 32'h2000 + ($urandom & 32'h0000FFFF);
      else if (r == 1) a = $urandom;
      else a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      model(o, a, wd, me, ml, mnr, mnw);
      run_op(o, a, wd, lat, e_o, rd_o, nr, nw, nena, nbad, da);
      checks++;
      if (lat !== ml || e_o !== me) begin
        errors++;
        $display("FAIL rand_lat_err op=%0d addr=%h got lat=%0d err=%b exp lat=%0d err=%b", o, a, lat, e_o, ml, me);
      end
      checks++;
      if (rd_o !== exp_rdata) begin
        errors++;
        $display("FAIL rand_rdata op=%0d addr=%h got %h exp %h", o, a, rd_o, exp_rdata);
      end
      checks++;
      if (nr !== mnr || nw !== mnw || nena !== mnr + mnw || nbad !== 0 || da !== 1'b0) begin
        errors++;
        $display("FAIL rand_bus op=%0d addr=%h got rd=%0d wr=%0d ena=%0d bad=%0d done_after=%b exp rd=%0d wr=%0d",
                 o, a, nr, nw, nena, nbad, da, mnr, mnw);
      end
      if ((a >> 2) < 32'd2048) begin
        checks++;
        if (mem[a[12:2]] !== ref_mem[a[12:2]]) begin
          errors++;
          $display("FAIL rand_mem op=%0d addr=%h got %h exp %h", o, a, mem[a[12:2]], ref_mem[a[12:2]]);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit me; int ml, mnr, mnw, ndone, lat;
    logic b1;
    model(SW, 32'h20, 32'hCAFEF00D, me, ml, mnr, mnw);
    @(negedge clk);
    start = 1'b1; op = SW; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(negedge clk);
    b1 = busy;
    start = 1'b1; op = SW; addr = 32'h24; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    lat = done ? 2 : 0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (b1 !== 1'b1 || lat !== ml) begin
      errors++;
      $display("FAIL busy_first got busy=%b lat=%0d exp busy=1 lat=%0d", b1, lat, ml);
    end
    checks++;
    if (ndone !== 0 || mem[9] !== ref_mem[9] || mem[8] !== ref_mem[8]) begin
      errors++;
      $display("FAIL busy_ignore got extra_done=%0d w8=%h w9=%h exp 0 %h %h", ndone, mem[8], mem[9], ref_mem[8], ref_mem[9]);
    end
  endtask

  task automatic test_reset_midop();
    int ndone, w;
    logic [2:0] o;
    o = SUBWORD ? SH : SW;
    @(negedge clk);
    start = 1'b1; op = o; addr = 32'h10; wdata = 32'h0000ABCD;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!DM_W && w < 5) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (DM_W !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_reach got DM_W=%b exp 1", DM_W);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, DM_ena, DM_R, DM_W} !== 5'b0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_idle got ctrl=%b rdata=%h exp 00000 0", {busy, done, DM_ena, DM_R, DM_W}, rdata);
    end
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL rst_mid_nodone got %0d active cycles exp 0", ndone);
    end
    exp_rdata = 32'd0;
    ref_mem[4] = mem[4];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_random();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
